// File: rtl/conv_window_mac_if.sv
// ============================================================================
// conv_window_mac_if : start/memory/result bundle for conv_window_mac
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_window_mac_if #(
   parameter int ACC_W = 32
);
   logic             i_start;
   logic [31:0]      i_base_addr;
   logic [5:0]       i_ker_base;
   logic [31:0]      o_addr_pic;
   logic [5:0]       o_addr_ker;
   logic [7:0]       i_read_pic;
   logic [15:0]      i_read_ker;
   logic [ACC_W-1:0] o_result;
   logic             o_valid;
   logic             i_ready;
   logic             o_busy;

   modport slave (
      input  i_start, i_base_addr, i_ker_base, i_read_pic, i_read_ker, i_ready,
      output o_addr_pic, o_addr_ker, o_result, o_valid, o_busy
   );

   modport master (
      output i_start, i_base_addr, i_ker_base, i_read_pic, i_read_ker, i_ready,
      input  o_addr_pic, o_addr_ker, o_result, o_valid, o_busy
   );
endinterface

`default_nettype wire

// File: rtl/conv_window_mac.sv
// ============================================================================
// conv_window_mac : KSIZE x KSIZE window multiply-accumulate, one result per window
// Optional macro CONV_SAT_EN: Q.FRAC shift and [0,255] clamp of the result.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_mac #(
   parameter int KSIZE = 3,
   parameter int IMG_W = 640,
   parameter int ACC_W = 32,
   parameter int FRAC  = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   conv_window_mac_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [5:0]  c_LAST_TAP = 6'(KSIZE*KSIZE-1);
   localparam logic [2:0]  c_COL_LAST = 3'(KSIZE-1);
   localparam logic [31:0] c_ROW_STEP = 32'(IMG_W-KSIZE+1);

   if ((KSIZE*KSIZE > 64) || (KSIZE > 8) || (ACC_W < 26) || (FRAC < 0) || (FRAC >= ACC_W)) begin : g_param_illegal
   end

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [31:0]             r_addr_pic;
   logic [5:0]              r_addr_ker;
   logic [5:0]              r_tap;
   logic [2:0]              r_col;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_prod;
   logic [ACC_W-1:0]        r_result;

   logic                    w_accept;
   logic                    w_last;
   logic signed [24:0]      w_prod;
   logic signed [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0]        w_result_nxt;

   // DONE only re-accepts START in the same cycle the result is taken
   assign w_accept = bus.i_start && ((r_state == S_IDLE) ||
                                     ((r_state == S_DONE) && bus.i_ready));
   assign w_last   = (r_tap == c_LAST_TAP);
   assign w_prod   = $signed({1'b0, bus.i_read_pic}) * $signed(bus.i_read_ker);
   assign w_sum    = r_acc + r_prod;

`ifdef CONV_SAT_EN
   logic signed [ACC_W-1:0] w_shift;
   logic [7:0]              w_clamp;

   assign w_shift = w_sum >>> FRAC;

   always_comb begin
      w_clamp = w_shift[7:0];
      if (w_shift[ACC_W-1]) begin
         w_clamp = 8'd0;
      end else if (|w_shift[ACC_W-2:8]) begin
         w_clamp = 8'hFF;
      end
   end

   assign w_result_nxt = {{(ACC_W-8){1'b0}}, w_clamp};
`else
   assign w_result_nxt = w_sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)   w_state_nxt = S_DRAIN;
         S_DRAIN:               w_state_nxt = S_DONE;
         S_DONE:  if (bus.i_ready) w_state_nxt = w_accept ? S_RUN : S_IDLE;
         default:               w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_pic <= '0;
         r_addr_ker <= '0;
         r_tap      <= '0;
         r_col      <= '0;
         r_acc      <= '0;
         r_prod     <= '0;
         r_result   <= '0;
      end else if (w_accept) begin
         r_addr_pic <= bus.i_base_addr;
         r_addr_ker <= bus.i_ker_base;
         r_tap      <= '0;
         r_col      <= '0;
         r_acc      <= '0;
         r_prod     <= '0;
      end else if (r_state == S_RUN) begin
         r_prod <= {{(ACC_W-25){w_prod[24]}}, w_prod};
         r_acc  <= w_sum;
         // Addresses stop on the last tap so they hold through DRAIN/DONE/IDLE
         if (!w_last) begin
            r_tap      <= r_tap + 6'd1;
            r_addr_ker <= r_addr_ker + 6'd1;
            if (r_col == c_COL_LAST) begin
               r_col      <= '0;
               r_addr_pic <= r_addr_pic + c_ROW_STEP;
            end else begin
               r_col      <= r_col + 3'd1;
               r_addr_pic <= r_addr_pic + 32'd1;
            end
         end
      end else if (r_state == S_DRAIN) begin
         r_acc    <= w_sum;
         r_prod   <= '0;
         r_result <= w_result_nxt;
      end
   end

   assign bus.o_addr_pic = r_addr_pic;
   assign bus.o_addr_ker = r_addr_ker;
   assign bus.o_result   = r_result;
   assign bus.o_valid    = (r_state == S_DONE);
   assign bus.o_busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_window_mac.sv
// ============================================================================
// tb_conv_window_mac : directed self-checking bench for conv_window_mac (IMG_W=8)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_mac;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   logic [7:0]  pix;
   logic [15:0] ker;

   conv_window_mac_if #(.ACC_W(32)) bus ();

   conv_window_mac #(
      .KSIZE (3),
      .IMG_W (8),
      .ACC_W (32),
      .FRAC  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.i_read_pic = pix;
   assign bus.i_read_ker = ker;

`ifdef CONV_SAT_EN
   localparam logic [31:0] c_EXP_ONES  = 32'd0;
   localparam logic [31:0] c_EXP_BOX   = 32'd90;
   localparam logic [31:0] c_EXP_NEG   = 32'd0;
   localparam logic [31:0] c_EXP_BIG   = 32'd255;
`else
   localparam logic [31:0] c_EXP_ONES  = 32'd9;
   localparam logic [31:0] c_EXP_BOX   = 32'd23040;
   localparam logic [31:0] c_EXP_NEG   = 32'hFFF8F800;
   localparam logic [31:0] c_EXP_BIG   = 32'd1175040;
`endif

   task automatic launch(input logic [31:0] base, input logic [5:0] kb);
      @(negedge clk);
      bus.i_base_addr = base;
      bus.i_ker_base  = kb;
      bus.i_start     = 1'b1;
      @(posedge clk);
      #1 bus.i_start  = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      logic seen;
      seen = 1'b0;
      lat  = -1;
      for (int k = 0; k < 40; k++) begin
         if (!seen && bus.o_valid) begin
            lat  = k;
            seen = 1'b1;
         end
         if (!seen) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic consume();
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1 bus.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      tests++; if (bus.o_addr_pic !== 32'd0) begin fails++; $display("FAIL reset_addr_pic: got %0d expected 0", bus.o_addr_pic); end
      tests++; if (bus.o_addr_ker !== 6'd0) begin fails++; $display("FAIL reset_addr_ker: got %0d expected 0", bus.o_addr_ker); end
      tests++; if (bus.o_result !== 32'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", bus.o_result); end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
   endtask

   task automatic test_addr_walk();
      logic [31:0] exp_pic [9];
      exp_pic = '{32'd100, 32'd101, 32'd102, 32'd108, 32'd109, 32'd110, 32'd116, 32'd117, 32'd118};
      pix = 8'd1;
      ker = 16'd1;
      launch(32'd100, 6'd5);
      for (int k = 0; k <= 10; k++) begin
         if (k <= 8) begin
            tests++; if (bus.o_addr_pic !== exp_pic[k]) begin fails++; $display("FAIL walk_addr_pic[%0d]: got %0d expected %0d", k, bus.o_addr_pic, exp_pic[k]); end
            tests++; if (bus.o_addr_ker !== 6'(5 + k)) begin fails++; $display("FAIL walk_addr_ker[%0d]: got %0d expected %0d", k, bus.o_addr_ker, 5 + k); end
         end else begin
            tests++; if (bus.o_addr_pic !== 32'd118) begin fails++; $display("FAIL walk_addr_hold[%0d]: got %0d expected 118", k, bus.o_addr_pic); end
         end
         tests++; if (bus.o_valid !== (k == 10)) begin fails++; $display("FAIL walk_valid[%0d]: got %b expected %b", k, bus.o_valid, (k == 10)); end
         if (k < 10) begin
            @(posedge clk);
            #1;
         end
      end
      tests++; if (bus.o_result !== c_EXP_ONES) begin fails++; $display("FAIL walk_result: got %0d expected %0d", bus.o_result, c_EXP_ONES); end
      consume();
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL walk_valid_drop: got %b expected 0", bus.o_valid); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL walk_busy_idle: got %b expected 0", bus.o_busy); end
   endtask

   task automatic test_box();
      int lat;
      pix = 8'd10;
      ker = 16'h0100;
      launch(32'd0, 6'd0);
      wait_valid(lat);
      tests++; if (lat !== 10) begin fails++; $display("FAIL box_latency: got %0d expected 10", lat); end
      tests++; if (bus.o_result !== c_EXP_BOX) begin fails++; $display("FAIL box_result: got %0d expected %0d", bus.o_result, c_EXP_BOX); end
      consume();
   endtask

   task automatic test_signed_clamp();
      int lat;
      pix = 8'd200;
      ker = 16'hFF00;
      launch(32'd40, 6'd60);
      wait_valid(lat);
      tests++; if (lat !== 10) begin fails++; $display("FAIL neg_latency: got %0d expected 10", lat); end
      tests++; if (bus.o_result !== c_EXP_NEG) begin fails++; $display("FAIL neg_result: got %h expected %h", bus.o_result, c_EXP_NEG); end
      tests++; if (bus.o_addr_ker !== 6'd4) begin fails++; $display("FAIL ker_addr_wrap: got %0d expected 4", bus.o_addr_ker); end
      consume();
      pix = 8'd255;
      ker = 16'h0200;
      launch(32'd0, 6'd0);
      wait_valid(lat);
      tests++; if (bus.o_result !== c_EXP_BIG) begin fails++; $display("FAIL big_result: got %0d expected %0d", bus.o_result, c_EXP_BIG); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      pix = 8'd10;
      ker = 16'h0100;
      launch(32'd0, 6'd0);
      repeat (3) @(posedge clk);
      #1;
      bus.i_base_addr = 32'd500;
      bus.i_start     = 1'b1;
      @(posedge clk);
      #1 bus.i_start  = 1'b0;
      wait_valid(lat);
      tests++; if (lat !== 6) begin fails++; $display("FAIL bp_latency_after_start_in_run: got %0d expected 6", lat); end
      tests++; if (bus.o_addr_pic !== 32'd18) begin fails++; $display("FAIL bp_addr_hold: got %0d expected 18", bus.o_addr_pic); end
      for (int c = 0; c < 5; c++) begin
         bus.i_start = (c == 2);
         @(posedge clk);
         #1;
         tests++; if (bus.o_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, bus.o_valid); end
         tests++; if (bus.o_result !== c_EXP_BOX) begin fails++; $display("FAIL bp_result[%0d]: got %0d expected %0d", c, bus.o_result, c_EXP_BOX); end
      end
      bus.i_start = 1'b0;
      consume();
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop: got %b expected 0", bus.o_valid); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL bp_busy_idle: got %b expected 0", bus.o_busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      pix = 8'd10;
      ker = 16'h0100;
      launch(32'd0, 6'd0);
      wait_valid(lat);
      tests++; if (lat !== 10) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 10", lat); end
      bus.i_base_addr = 32'd300;
      bus.i_ker_base  = 6'd7;
      bus.i_start     = 1'b1;
      bus.i_ready     = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_ready = 1'b0;
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop: got %b expected 0", bus.o_valid); end
      tests++; if (bus.o_addr_pic !== 32'd300) begin fails++; $display("FAIL b2b_addr_pic: got %0d expected 300", bus.o_addr_pic); end
      tests++; if (bus.o_addr_ker !== 6'd7) begin fails++; $display("FAIL b2b_addr_ker: got %0d expected 7", bus.o_addr_ker); end
      tests++; if (bus.o_busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b expected 1", bus.o_busy); end
      wait_valid(lat);
      tests++; if (lat !== 10) begin fails++; $display("FAIL b2b_second_latency: got %0d expected 10", lat); end
      tests++; if (bus.o_result !== c_EXP_BOX) begin fails++; $display("FAIL b2b_result: got %0d expected %0d", bus.o_result, c_EXP_BOX); end
      consume();
   endtask

   task automatic test_async_reset();
      int lat;
      pix = 8'd255;
      ker = 16'h0200;
      launch(32'd0, 6'd0);
      repeat (4) @(posedge clk);
      #1;
      tests++; if (bus.o_addr_pic !== 32'd9) begin fails++; $display("FAIL ar_tap4_addr: got %0d expected 9", bus.o_addr_pic); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus.o_addr_pic !== 32'd0) begin fails++; $display("FAIL ar_addr_pic: got %0d expected 0", bus.o_addr_pic); end
      tests++; if (bus.o_addr_ker !== 6'd0) begin fails++; $display("FAIL ar_addr_ker: got %0d expected 0", bus.o_addr_ker); end
      tests++; if (bus.o_result !== 32'd0) begin fails++; $display("FAIL ar_result: got %0d expected 0", bus.o_result); end
      tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL ar_busy: got %b expected 0", bus.o_busy); end
      tests++; if (bus.o_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b expected 0", bus.o_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      pix = 8'd10;
      ker = 16'h0100;
      launch(32'd0, 6'd0);
      wait_valid(lat);
      tests++; if (lat !== 10) begin fails++; $display("FAIL ar_fresh_latency: got %0d expected 10", lat); end
      tests++; if (bus.o_result !== c_EXP_BOX) begin fails++; $display("FAIL ar_fresh_result: got %0d expected %0d", bus.o_result, c_EXP_BOX); end
      consume();
   endtask

   initial begin
      bus.i_start     = 1'b0;
      bus.i_base_addr = 32'd0;
      bus.i_ker_base  = 6'd0;
      bus.i_ready     = 1'b0;
      pix             = 8'd0;
      ker             = 16'd0;
      #2;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_addr_walk();
      test_box();
      test_signed_clamp();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream consumer of the pixel/kernel memory path in the convolution datapath.
- For one output pixel, it walks a KSIZE x KSIZE window:
  - drives pixel and kernel read addresses,
  - multiplies the returned 8-bit pixel by the 16-bit signed kernel coefficient,
  - accumulates the products.
- Delivers one result per window over a VALID/READY handshake to the writeback stage.
- Pixel and kernel memories are asynchronous-read, so read data is valid in the same cycle as the address.

Parameters:
- KSIZE, 3, window side; KSIZE*KSIZE must be <= 64.
- IMG_W, 640, image row pitch in pixels.
- ACC_W, 32, accumulator/result width; must be >= 26.
- FRAC, 8, kernel fractional bits (Q.FRAC); used only by the optional feature.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request one window computation; sampled only in IDLE, or in DONE when the result handshake completes that same cycle.
- BASE_ADDR  in  32  pixel address of the window's top-left pixel; captured on accepted START.
- KER_BASE  in  6  kernel address of tap 0; captured on accepted START.
- ADDR_PIC  out  32  pixel memory address.
- ADDR_KER  out  6  kernel memory address.
- READ_PIC  in  8  pixel data, unsigned.
- READ_KER  in  16  kernel coefficient, two's complement.
- RESULT  out  ACC_W  window result.
- VALID  out  1  RESULT valid.
- READY  in  1  downstream accepts RESULT.
- BUSY  out  1  high in RUN, DRAIN and DONE.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE.
  - ADDR_PIC=0, ADDR_KER=0, RESULT=0, VALID=0, BUSY=0.
  - Accumulator, product register and tap/row/column counters cleared.
  - Reset mid-operation aborts the window; no partial result is ever presented.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - START=1 at edge E0: capture BASE_ADDR and KER_BASE, clear accumulator, tap=0, go RUN.
  - ADDR_PIC=BASE_ADDR and ADDR_KER=KER_BASE from E0.
- RUN, one tap per cycle, taps 0..KSIZE*KSIZE-1, row-major:
  - Each edge: product register <= zero-extended READ_PIC (9-bit signed) x READ_KER, giving a 25-bit signed product sign-extended to ACC_W.
  - Accumulator <= accumulator + previous product (first add is of 0).
- Address stepping (no multiplier):
  - ADDR_PIC +1 within a row.
  - At the end of a row, ADDR_PIC += IMG_W-KSIZE+1.
  - ADDR_KER = KER_BASE + tap, modulo 64.
  - ADDR_PIC wraps modulo 2^32 silently.
- Transition: after the edge that loads the last product, go DRAIN.
- DRAIN: one edge adds the last product, then go DONE with VALID=1.
- Latency: VALID rises KSIZE*KSIZE+1 edges after E0 (10 for KSIZE=3).
- DONE:
  - RESULT holds the accumulator; RESULT and VALID stay stable while READY=0.
  - READY=1 with START=0: VALID drops next cycle, go IDLE.
  - READY=1 with START=1: result is consumed and a new window starts back-to-back (same as the IDLE acceptance); VALID=0 next cycle.
- START in RUN or DRAIN is ignored.
- In DONE, START without READY is ignored.
- ADDR_PIC and ADDR_KER hold their last values in DRAIN, DONE and IDLE.
- Accumulator overflow wraps modulo 2^ACC_W. It is unreachable for ACC_W>=32 and KSIZE<=8.

Optional Feature:
- Macro: CONV_SAT_EN.
- Defined:
  - RESULT = accumulator arithmetic-shifted right by FRAC, clamped to [0,255], zero-extended to ACC_W.
  - The clamp is registered on entry to DONE, so latency is unchanged.
- Undefined: RESULT is the raw accumulator; no shifter or clamp logic is present.

Test Plan:
- Address walk: IMG_W=8, BASE_ADDR=100, KER_BASE=5 -> ADDR_PIC sequence 100,101,102,108,109,110,116,117,118; ADDR_KER sequence 5..13; VALID exactly 10 cycles after START.
- Box filter: all pixels 10, all kernel 0x0100 -> raw RESULT 23040 (0x5A00); with CONV_SAT_EN, RESULT 90.
- Signed and clamp: pixels 200, kernel 0xFF00 (-1.0) -> raw RESULT -460800 (0xFFF8F800); with CONV_SAT_EN, RESULT 0. Pixels 255, kernel 0x0200 -> CONV_SAT_EN RESULT 255.
- Backpressure: READY=0 for 5 cycles in DONE -> RESULT and VALID stable; START pulses during RUN and in DONE without READY are ignored.
- Back-to-back: READY=1 and START=1 in the DONE cycle -> second window's ADDR_PIC=new BASE_ADDR next cycle, second VALID 11 cycles after the first.
- Async reset: RST_N low at tap 4 -> outputs 0 immediately (no clock edge); after release, a fresh START yields the correct full-window result.
